cga_vram_arbiter: RTL and testbench
===================================

# cga_vram_arbiter

Shares the single external 8-bit SRAM between the two VRAM requesters in the CGA design: the ISA bus CPU path (memory reads/writes to the frame buffer) and the CRTC character/attribute fetch path. It serializes accesses into fixed-length SRAM cycles and generates the ISA ready (wait-state) signal. It owns the ram_a / ram_we_l / ram_d pins. Video gets priority with guaranteed CPU fairness, so both latencies are bounded.

## Interface
- ACCESS_CYCLES, 2: clocks per SRAM access (min 2).
- ADDR_WIDTH, 19: SRAM address width.

- clk  in  1  pixel clock (28.636 MHz); all logic on rising edge
- reset  in  1  synchronous, active-high
- vid_req  in  1  one-cycle fetch request pulse
- vid_addr  in  ADDR_WIDTH  fetch address, valid with vid_req
- vid_data  out  8  fetched byte
- vid_valid  out  1  one-cycle pulse: vid_data valid
- cpu_req  in  1  one-cycle CPU access request pulse
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  ADDR_WIDTH  CPU address, valid with cpu_req
- cpu_wdata  in  8  write data, valid with cpu_req
- cpu_rdata  out  8  read data
- cpu_ack  out  1  one-cycle pulse: CPU access complete (cpu_rdata valid on reads)
- cpu_rdy  out  1  ISA ready; 0 while a CPU access is pending or in progress
- ram_a  out  ADDR_WIDTH  SRAM address
- ram_we_l  out  1  SRAM write enable, active low
- ram_d_out  out  8  SRAM write data
- ram_d_oe  out  1  drive ram_d with ram_d_out
- ram_d_in  in  8  SRAM read data

## Operation
- Request capture: a vid_req/cpu_req pulse sets that requester's pending flag and latches its address, plus we/wdata for CPU. A pulse arriving while the same requester is pending is dropped.
- FSM states: IDLE, ACCESS. Down-counter cnt runs from ACCESS_CYCLES-1 to 0. Owner register is VID or CPU. last_owner register.
- Arbitration happens in IDLE, or in ACCESS when cnt==0, and only over registered pending flags.
  - Only one pending: grant it.
  - Both pending: grant VID, unless last_owner==VID, in which case grant CPU.
  - Neither pending: go to IDLE, or stay there.
- Grant effects: owner and last_owner are set, the granted pending flag clears, cnt loads ACCESS_CYCLES-1, and the state is ACCESS.
- Read access: ram_a = latched address for all ACCESS_CYCLES cycles. ram_we_l=1, ram_d_oe=0. ram_d_in is sampled at the end of the cnt==0 cycle.
- Write access:
  - ram_a and ram_d_out are stable for all cycles, and ram_d_oe=1 for all cycles.
  - ram_we_l=0 on every cycle except the first, so address setup precedes WE.
  - Video is never a write.
- Completion: in the cycle after the cnt==0 cycle, the owner's valid/ack pulses for 1 cycle. vid_data or cpu_rdata is updated on reads and holds until the next read of that requester. cpu_ack also pulses on writes.
- cpu_rdy = 0 from the cycle after cpu_req through the cpu_ack cycle; otherwise 1.
- Outside ACCESS: ram_a holds its last value, ram_we_l=1, ram_d_oe=0.
- Reset mid-access: the access is aborted at the next edge. No ack/valid is issued, all pending flags are cleared, and all outputs return to reset values.
- Reset values:
  - state IDLE, last_owner=CPU
  - ram_a=0, ram_we_l=1, ram_d_out=0, ram_d_oe=0
  - vid_data=0, vid_valid=0, cpu_rdata=0, cpu_ack=0, cpu_rdy=1

## Timing
- Idle latency: request pulse at cycle 0, pending at 1, grant at 1, ACCESS at cycles 2..ACCESS_CYCLES+1, ack/valid at cycle ACCESS_CYCLES+2. This is 4 cycles for the default.
- Back-to-back: the grant at cnt==0 lets the next access start on the following cycle, with no idle gap. The write→read data turnaround relies on the SRAM's tri-state timing; no extra cycle is inserted.
- Worst-case wait for either requester is one foreign access. Video ≤ 2·ACCESS_CYCLES+2 cycles from pulse to valid.
- Simultaneous vid_req and cpu_req from IDLE after reset: VID is served first, then CPU.
- A request pulse in the same cycle that requester's ack/valid pulses is accepted, because pending is already clear.
- Each pending flag holds at most one request per requester; there is no queue.

## Test plan
- CPU read after reset: SRAM model holds 0x5A at 0x00123. cpu_req(we=0, addr 0x00123) at cycle 0 -> ram_a=0x00123 on cycles 2-3, cpu_rdy=0 on cycles 1-4, cpu_ack and cpu_rdata=0x5A at cycle 4, cpu_rdy=1 at cycle 5.
- CPU write: cpu_req(we=1, addr 0x07FFF, data 0xA5) -> ram_d_oe=1 on cycles 2-3, ram_we_l=0 on cycle 3 only, cpu_ack at cycle 4, and the model stores 0xA5.
- Simultaneous: vid_req(0x00010) and cpu_req(read 0x00020) in the same cycle -> video access on cycles 2-3, CPU access on cycles 4-5 with no gap, vid_valid at 4, cpu_ack at 6.
- Fairness: vid_req pulsed every 2 cycles while cpu_req is pending -> the CPU is granted immediately after the first video access, and accesses alternate VID, CPU, VID. cpu_ack arrives within 6 cycles.
- Overrun: a second vid_req while video is pending -> dropped, and exactly one vid_valid is produced.
- Reset mid-write: assert reset on cycle 3 of a write -> ram_we_l=1 and ram_d_oe=0 at the next edge, no cpu_ack, cpu_rdy=1, and a new request afterwards completes normally.

Source files
------------

// File: rtl/cga_vram_arbiter.sv
// Shares the single 8-bit VRAM SRAM between the CRTC fetch path and the ISA CPU path.
// Video has priority, but a CPU request always wins against a second video request in a row.
module cga_vram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned ADDR_WIDTH    = 19
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_vid_req,
    input  logic [ADDR_WIDTH-1:0] i_vid_addr,
    output logic [7:0]            o_vid_data,
    output logic                  o_vid_valid,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [7:0]            i_cpu_wdata,
    output logic [7:0]            o_cpu_rdata,
    output logic                  o_cpu_ack,
    output logic                  o_cpu_rdy,
    output logic [ADDR_WIDTH-1:0] o_ram_a,
    output logic                  o_ram_we_l,
    output logic [7:0]            o_ram_d_out,
    output logic                  o_ram_d_oe,
    input  logic [7:0]            i_ram_d_in
);

    localparam int unsigned CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;
    typedef enum logic {OWN_VID, OWN_CPU} owner_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    owner_t                r_owner;
    owner_t                r_last_owner;
    logic                  r_vid_pend;
    logic                  r_cpu_pend;
    logic [ADDR_WIDTH-1:0] r_vid_addr;
    logic [ADDR_WIDTH-1:0] r_cpu_addr;
    logic                  r_cpu_we;
    logic [7:0]            r_cpu_wdata;
    logic                  r_acc_we;
    logic [ADDR_WIDTH-1:0] r_ram_a;
    logic                  r_ram_we_l;
    logic [7:0]            r_ram_d_out;
    logic                  r_ram_d_oe;
    logic [7:0]            r_vid_data;
    logic                  r_vid_valid;
    logic [7:0]            r_cpu_rdata;
    logic                  r_cpu_ack;
    logic                  r_cpu_rdy;

    logic w_arb;
    logic w_done;
    logic w_grant_vid;
    logic w_grant_cpu;
    logic w_vid_pend_next;
    logic w_cpu_pend_next;
    logic w_cpu_busy_next;
    logic w_cpu_ack_next;
    logic w_cpu_rdy_next;

    // Next-state logic: arbitrate only when idle or on the last cycle of an access.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant_vid  = 1'b0;
        w_grant_cpu  = 1'b0;
        w_done       = 1'b0;
        w_arb        = (r_state == ST_IDLE) || (r_cnt == '0);
        if (r_state == ST_ACCESS) begin
            if (r_cnt == '0) begin
                w_done = 1'b1;
            end else begin
                w_cnt_next = r_cnt - CNT_W'(1);
            end
        end
        if (w_arb) begin
            if (r_vid_pend && (!r_cpu_pend || (r_last_owner == OWN_CPU))) begin
                w_grant_vid = 1'b1;
            end else if (r_cpu_pend) begin
                w_grant_cpu = 1'b1;
            end
            if (w_grant_vid || w_grant_cpu) begin
                w_state_next = ST_ACCESS;
                w_cnt_next   = CNT_LOAD;
            end else begin
                w_state_next = ST_IDLE;
            end
        end
    end

    assign w_vid_pend_next = (r_vid_pend && !w_grant_vid) || (i_vid_req && !r_vid_pend);
    assign w_cpu_pend_next = (r_cpu_pend && !w_grant_cpu) || (i_cpu_req && !r_cpu_pend);
    assign w_cpu_busy_next = (w_state_next == ST_ACCESS) &&
                             (w_grant_cpu || (!w_grant_vid && (r_owner == OWN_CPU)));
    assign w_cpu_ack_next  = w_done && (r_owner == OWN_CPU);
    assign w_cpu_rdy_next  = !(w_cpu_pend_next || w_cpu_busy_next || w_cpu_ack_next);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_owner      <= OWN_CPU;
            r_last_owner <= OWN_CPU;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_grant_vid) begin
                r_owner      <= OWN_VID;
                r_last_owner <= OWN_VID;
            end else if (w_grant_cpu) begin
                r_owner      <= OWN_CPU;
                r_last_owner <= OWN_CPU;
            end
        end
    end

    // Request capture; a pulse while already pending is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vid_pend  <= 1'b0;
            r_cpu_pend  <= 1'b0;
            r_vid_addr  <= '0;
            r_cpu_addr  <= '0;
            r_cpu_we    <= 1'b0;
            r_cpu_wdata <= '0;
        end else begin
            r_vid_pend <= w_vid_pend_next;
            r_cpu_pend <= w_cpu_pend_next;
            if (i_vid_req && !r_vid_pend) begin
                r_vid_addr <= i_vid_addr;
            end
            if (i_cpu_req && !r_cpu_pend) begin
                r_cpu_addr  <= i_cpu_addr;
                r_cpu_we    <= i_cpu_we;
                r_cpu_wdata <= i_cpu_wdata;
            end
        end
    end

    // SRAM pins: WE is held off for the first cycle so the address settles first.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ram_a     <= '0;
            r_ram_we_l  <= 1'b1;
            r_ram_d_out <= '0;
            r_ram_d_oe  <= 1'b0;
            r_acc_we    <= 1'b0;
        end else if (w_grant_vid) begin
            r_ram_a    <= r_vid_addr;
            r_ram_we_l <= 1'b1;
            r_ram_d_oe <= 1'b0;
            r_acc_we   <= 1'b0;
        end else if (w_grant_cpu) begin
            r_ram_a     <= r_cpu_addr;
            r_ram_d_out <= r_cpu_wdata;
            r_ram_we_l  <= 1'b1;
            r_ram_d_oe  <= r_cpu_we;
            r_acc_we    <= r_cpu_we;
        end else if ((r_state == ST_ACCESS) && !w_done) begin
            r_ram_we_l <= !r_acc_we;
        end else begin
            r_ram_we_l <= 1'b1;
            r_ram_d_oe <= 1'b0;
        end
    end

    // Completion pulses and read data capture.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
            r_cpu_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdy   <= 1'b1;
        end else begin
            r_vid_valid <= w_done && (r_owner == OWN_VID);
            r_cpu_ack   <= w_cpu_ack_next;
            r_cpu_rdy   <= w_cpu_rdy_next;
            if (w_done && (r_owner == OWN_VID)) begin
                r_vid_data <= i_ram_d_in;
            end
            if (w_cpu_ack_next && !r_acc_we) begin
                r_cpu_rdata <= i_ram_d_in;
            end
        end
    end

    assign o_vid_data  = r_vid_data;
    assign o_vid_valid = r_vid_valid;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_cpu_rdy   = r_cpu_rdy;
    assign o_ram_a     = r_ram_a;
    assign o_ram_we_l  = r_ram_we_l;
    assign o_ram_d_out = r_ram_d_out;
    assign o_ram_d_oe  = r_ram_d_oe;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter with a simple asynchronous-read SRAM model.
module tb_cga_vram_arbiter;

    localparam int unsigned AW = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic          vid_valid;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;
    logic          cpu_rdy;
    logic [AW-1:0] ram_a;
    logic          ram_we_l;
    logic [7:0]    ram_d_out;
    logic          ram_d_oe;
    logic [7:0]    ram_d_in;

    logic [7:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;
    int vcount;

    always #5 clk = ~clk;

    cga_vram_arbiter #(.ACCESS_CYCLES(2), .ADDR_WIDTH(AW)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_vid_req   (vid_req),
        .i_vid_addr  (vid_addr),
        .o_vid_data  (vid_data),
        .o_vid_valid (vid_valid),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_ack   (cpu_ack),
        .o_cpu_rdy   (cpu_rdy),
        .o_ram_a     (ram_a),
        .o_ram_we_l  (ram_we_l),
        .o_ram_d_out (ram_d_out),
        .o_ram_d_oe  (ram_d_oe),
        .i_ram_d_in  (ram_d_in)
    );

    assign ram_d_in = mem[ram_a];

    always @(posedge clk) begin
        if (!ram_we_l && ram_d_oe) mem[ram_a] <= ram_d_out;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_pulse(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    initial begin
        reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem[19'h00123] = 8'h5A; mem[19'h07FFF] = 8'h00;
        mem[19'h00010] = 8'h11; mem[19'h00020] = 8'h22;
        mem[19'h00030] = 8'h33; mem[19'h00031] = 8'h34; mem[19'h00032] = 8'h35;
        mem[19'h00040] = 8'h44; mem[19'h00050] = 8'h55; mem[19'h00051] = 8'h56;
        mem[19'h00060] = 8'h00;
        step(); step(); step();

        check_eq("rst_ram_a", 32'(ram_a), 32'h0);
        check_eq("rst_we_l", 32'(ram_we_l), 32'h1);
        check_eq("rst_d_oe", 32'(ram_d_oe), 32'h0);
        check_eq("rst_d_out", 32'(ram_d_out), 32'h0);
        check_eq("rst_vid_valid", 32'(vid_valid), 32'h0);
        check_eq("rst_vid_data", 32'(vid_data), 32'h0);
        check_eq("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        check_eq("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check_eq("rst_cpu_rdy", 32'(cpu_rdy), 32'h1);
        reset = 1'b0;
        step();

        // CPU read after reset
        cpu_pulse(1'b0, 19'h00123, 8'h00);
        step(); cpu_req = 1'b0;
        check_eq("rd_rdy_c1", 32'(cpu_rdy), 32'h0);
        step();
        check_eq("rd_ram_a_c2", 32'(ram_a), 32'h00123);
        check_eq("rd_we_l_c2", 32'(ram_we_l), 32'h1);
        check_eq("rd_oe_c2", 32'(ram_d_oe), 32'h0);
        check_eq("rd_rdy_c2", 32'(cpu_rdy), 32'h0);
        step();
        check_eq("rd_ram_a_c3", 32'(ram_a), 32'h00123);
        check_eq("rd_ack_c3", 32'(cpu_ack), 32'h0);
        step();
        check_eq("rd_ack_c4", 32'(cpu_ack), 32'h1);
        check_eq("rd_rdata_c4", 32'(cpu_rdata), 32'h5A);
        check_eq("rd_rdy_c4", 32'(cpu_rdy), 32'h0);
        step();
        check_eq("rd_rdy_c5", 32'(cpu_rdy), 32'h1);
        check_eq("rd_ack_c5", 32'(cpu_ack), 32'h0);
        step();

        // CPU write
        cpu_pulse(1'b1, 19'h07FFF, 8'hA5);
        step(); cpu_req = 1'b0;
        step();
        check_eq("wr_oe_c2", 32'(ram_d_oe), 32'h1);
        check_eq("wr_we_l_c2", 32'(ram_we_l), 32'h1);
        check_eq("wr_ram_a_c2", 32'(ram_a), 32'h07FFF);
        check_eq("wr_d_out_c2", 32'(ram_d_out), 32'hA5);
        step();
        check_eq("wr_oe_c3", 32'(ram_d_oe), 32'h1);
        check_eq("wr_we_l_c3", 32'(ram_we_l), 32'h0);
        step();
        check_eq("wr_ack_c4", 32'(cpu_ack), 32'h1);
        check_eq("wr_we_l_c4", 32'(ram_we_l), 32'h1);
        check_eq("wr_oe_c4", 32'(ram_d_oe), 32'h0);
        check_eq("wr_mem", 32'(mem[19'h07FFF]), 32'hA5);
        check_eq("wr_rdata_hold", 32'(cpu_rdata), 32'h5A);
        step(); step();

        // Simultaneous requests: video first, CPU back-to-back
        vid_req = 1'b1; vid_addr = 19'h00010;
        cpu_pulse(1'b0, 19'h00020, 8'h00);
        step(); vid_req = 1'b0; cpu_req = 1'b0;
        step();
        check_eq("sim_ram_a_c2", 32'(ram_a), 32'h00010);
        step();
        check_eq("sim_ram_a_c3", 32'(ram_a), 32'h00010);
        step();
        check_eq("sim_ram_a_c4", 32'(ram_a), 32'h00020);
        check_eq("sim_vvalid_c4", 32'(vid_valid), 32'h1);
        check_eq("sim_vdata_c4", 32'(vid_data), 32'h11);
        check_eq("sim_ack_c4", 32'(cpu_ack), 32'h0);
        step();
        check_eq("sim_ram_a_c5", 32'(ram_a), 32'h00020);
        check_eq("sim_vvalid_c5", 32'(vid_valid), 32'h0);
        step();
        check_eq("sim_ack_c6", 32'(cpu_ack), 32'h1);
        check_eq("sim_rdata_c6", 32'(cpu_rdata), 32'h22);
        step(); step();

        // Fairness: video pulses every 2 cycles while the CPU waits
        vcount = 0;
        for (int c = 0; c < 12; c++) begin
            vid_req  = (c == 0) || (c == 2) || (c == 4);
            vid_addr = (c == 0) ? 19'h00030 : (c == 2) ? 19'h00031 : 19'h00032;
            cpu_req  = (c == 0);
            cpu_we   = 1'b0;
            cpu_addr = 19'h00040;
            if (c >= 2 && c <= 7) begin
                check_eq($sformatf("fair_ram_a_c%0d", c), 32'(ram_a),
                         (c < 4) ? 32'h30 : (c < 6) ? 32'h40 : 32'h31);
            end
            check_eq($sformatf("fair_ack_c%0d", c), 32'(cpu_ack), 32'(c == 6));
            if (vid_valid) vcount++;
            if (c == 4) check_eq("fair_vdata_c4", 32'(vid_data), 32'h33);
            if (c == 6) check_eq("fair_rdata_c6", 32'(cpu_rdata), 32'h44);
            if (c == 8) check_eq("fair_vdata_c8", 32'(vid_data), 32'h34);
            step();
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        check_eq("fair_vvalid_count", 32'(vcount), 32'd2);

        // Overrun: second video pulse while pending is dropped
        vcount = 0;
        vid_req = 1'b1; vid_addr = 19'h00050;
        step(); vid_addr = 19'h00051;
        step(); vid_req = 1'b0;
        check_eq("ovr_ram_a_c2", 32'(ram_a), 32'h00050);
        for (int c = 2; c < 10; c++) begin
            if (vid_valid) vcount++;
            if (c == 4) check_eq("ovr_vdata_c4", 32'(vid_data), 32'h55);
            step();
        end
        check_eq("ovr_vvalid_count", 32'(vcount), 32'd1);

        // Reset asserted during the WE cycle of a write
        cpu_pulse(1'b1, 19'h00060, 8'h77);
        step(); cpu_req = 1'b0;
        step();
        check_eq("rstw_oe_c2", 32'(ram_d_oe), 32'h1);
        step();
        check_eq("rstw_we_l_c3", 32'(ram_we_l), 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rstw_we_l_c4", 32'(ram_we_l), 32'h1);
        check_eq("rstw_oe_c4", 32'(ram_d_oe), 32'h0);
        check_eq("rstw_ack_c4", 32'(cpu_ack), 32'h0);
        check_eq("rstw_rdy_c4", 32'(cpu_rdy), 32'h1);
        check_eq("rstw_ram_a_c4", 32'(ram_a), 32'h0);
        step();
        check_eq("rstw_ack_c5", 32'(cpu_ack), 32'h0);
        check_eq("rstw_rdy_c5", 32'(cpu_rdy), 32'h1);
        step();

        cpu_pulse(1'b0, 19'h00123, 8'h00);
        step(); cpu_req = 1'b0;
        step(); step();
        check_eq("post_ack_c3", 32'(cpu_ack), 32'h0);
        step();
        check_eq("post_ack_c4", 32'(cpu_ack), 32'h1);
        check_eq("post_rdata_c4", 32'(cpu_rdata), 32'h5A);
        step();
        check_eq("post_rdy_c5", 32'(cpu_rdy), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
